// File: rtl/ibex_pkg.sv
// Shared types and constants for the shadow-stack controller and its operation queue.
package ibex_pkg;

    typedef enum logic {
        SS_PUSH = 1'b0,
        SS_POP  = 1'b1
    } ss_op_e;

    typedef enum logic [1:0] {
        SS_ERR_NONE      = 2'd0,
        SS_ERR_OVERFLOW  = 2'd1,
        SS_ERR_UNDERFLOW = 2'd2,
        SS_ERR_MISMATCH  = 2'd3
    } ss_err_e;

    typedef enum logic [1:0] {
        SS_IDLE  = 2'd0,
        SS_RUN   = 2'd1,
        SS_FAULT = 2'd2
    } ss_ctrl_state_e;

    localparam logic [4:0] SS_LINK_X1   = 5'd1;
    localparam logic [4:0] SS_LINK_X5   = 5'd5;
    localparam logic [6:0] SS_OPC_JAL   = 7'h6F;
    localparam logic [6:0] SS_OPC_JALR  = 7'h67;

    // One queued stack operation: 33 bits {op, value}.
    typedef struct packed {
        ss_op_e      op;
        logic [31:0] value;
    } ss_entry_t;

    function automatic logic ss_is_link(input logic [4:0] reg_idx);
        return (reg_idx == SS_LINK_X1) || (reg_idx == SS_LINK_X5);
    endfunction

endpackage

// File: rtl/ibex_ss_op_fifo.sv
// Small operation queue: up to two entries enqueued per cycle, one dequeued, flush has priority.
module ibex_ss_op_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push0_i,
    input  ss_entry_t                push0_data_i,
    input  logic                     push1_i,
    input  ss_entry_t                push1_data_i,
    input  logic                     pop_i,
    output ss_entry_t                head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   free_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    ss_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_pop;
    logic [CNT_W-1:0] w_n_push;
    logic [PTR_W-1:0] w_wr_ptr_1;

    assign w_pop      = pop_i & (r_count != '0);
    assign w_n_push   = CNT_W'(push0_i) + CNT_W'(push1_i);
    assign w_wr_ptr_1 = r_wr_ptr + PTR_W'(1);

    assign head_o  = r_mem[r_rd_ptr];
    assign empty_o = (r_count == '0);
    assign free_o  = CNT_W'(DEPTH) - r_count;

    // push1_i is only ever raised together with push0_i, so it lands in the slot after it.
    always_ff @(posedge clk_i) begin
        if (!flush_i) begin
            if (push0_i) r_mem[r_wr_ptr]   <= push0_data_i;
            if (push1_i) r_mem[w_wr_ptr_1] <= push1_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_push);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= r_count + w_n_push - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/ibex_shadow_stack_ctrl.sv
// Decodes retiring JAL/JALR into shadow-stack push/pop requests, queues and issues them,
// mirrors stack depth and latches a sticky error cause with a one-cycle fault pulse.
module ibex_shadow_stack_ctrl
    import ibex_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic                  instr_valid_i,
    input  logic [31:0]           instr_i,
    input  logic                  instr_compressed_i,
    input  logic [31:0]           pc_i,
    input  logic [31:0]           jump_target_i,
    output logic                  stall_o,
    output logic [31:0]           ss_pointer_wr_o,
    output logic [31:0]           ss_pointer_rd_o,
    output logic                  ss_write_o,
    output logic                  ss_read_o,
    input  logic                  ss_error_i,
    output logic                  fault_o,
    output logic [1:0]            err_cause_o,
    output logic [ADDR_WIDTH-1:0] ss_depth_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_MAX = '1;

    ss_ctrl_state_e        r_state;
    ss_err_e               r_cause;
    logic                  r_fault;
    logic [ADDR_WIDTH-1:0] r_depth;

    logic [4:0]       w_rd;
    logic [4:0]       w_rs1;
    logic             w_rd_link;
    logic             w_rs1_link;
    logic             w_is_jal;
    logic             w_is_jalr;
    logic [31:0]      w_link_addr;
    logic             w_run;
    logic             w_stall;
    logic             w_accept;
    logic             w_op0_v;
    logic             w_op1_v;
    ss_entry_t        w_op0;
    ss_entry_t        w_op1;
    ss_entry_t        w_head;
    logic             w_empty;
    logic [CNT_W-1:0] w_free;
    logic             w_issue;
    logic             w_write;
    logic             w_read;
    logic             w_error;
    ss_err_e          w_cause;
    logic             w_unused;

    assign w_rd        = instr_i[11:7];
    assign w_rs1       = instr_i[19:15];
    assign w_rd_link   = ss_is_link(w_rd);
    assign w_rs1_link  = ss_is_link(w_rs1);
    assign w_is_jal    = (instr_i[6:0] == SS_OPC_JAL);
    assign w_is_jalr   = (instr_i[6:0] == SS_OPC_JALR) && (instr_i[14:12] == 3'b000);
    assign w_link_addr = pc_i + (instr_compressed_i ? 32'd2 : 32'd4);
    assign w_unused    = ^instr_i[31:20];

    // Two free slots are demanded so a POP+PUSH pair never has to be split across cycles.
    assign w_run    = (r_state == SS_RUN);
    assign w_stall  = w_run & enable_i & instr_valid_i & (w_free < CNT_W'(2));
    assign w_accept = w_run & enable_i & instr_valid_i & ~w_stall;

    always_comb begin
        w_op0_v     = 1'b0;
        w_op1_v     = 1'b0;
        w_op0.op    = SS_PUSH;
        w_op0.value = w_link_addr;
        w_op1.op    = SS_PUSH;
        w_op1.value = w_link_addr;
        if (w_accept) begin
            if (w_is_jal) begin
                w_op0_v = w_rd_link;
            end else if (w_is_jalr) begin
                if (w_rd_link && w_rs1_link && (w_rd != w_rs1)) begin
                    w_op0_v     = 1'b1;
                    w_op0.op    = SS_POP;
                    w_op0.value = jump_target_i;
                    w_op1_v     = 1'b1;
                end else if (w_rd_link) begin
                    w_op0_v = 1'b1;
                end else if (w_rs1_link) begin
                    w_op0_v     = 1'b1;
                    w_op0.op    = SS_POP;
                    w_op0.value = jump_target_i;
                end
            end
        end
    end

    ibex_ss_op_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_op_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (w_error),
        .push0_i      (w_op0_v),
        .push0_data_i (w_op0),
        .push1_i      (w_op1_v),
        .push1_data_i (w_op1),
        .pop_i        (w_issue),
        .head_o       (w_head),
        .empty_o      (w_empty),
        .free_o       (w_free)
    );

    assign w_issue = w_run & ~w_empty;
    assign w_write = w_issue & (w_head.op == SS_PUSH);
    assign w_read  = w_issue & (w_head.op == SS_POP);
    assign w_error = w_issue & ss_error_i;

    always_comb begin
        w_cause = SS_ERR_MISMATCH;
        if (w_head.op == SS_PUSH) begin
            w_cause = SS_ERR_OVERFLOW;
        end else if (r_depth == '0) begin
            w_cause = SS_ERR_UNDERFLOW;
        end
    end

    // The mirror follows the stack itself: failed pops still consume an entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_depth <= '0;
        end else if (w_write && (r_depth != DEPTH_MAX)) begin
            r_depth <= r_depth + 1'b1;
        end else if (w_read && (r_depth != '0)) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= SS_IDLE;
            r_cause <= SS_ERR_NONE;
            r_fault <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                SS_IDLE: begin
                    if (enable_i) r_state <= SS_RUN;
                end
                SS_RUN: begin
                    if (w_error) begin
                        r_state <= SS_FAULT;
                        r_cause <= w_cause;
                        r_fault <= 1'b1;
                    end else if (!enable_i && w_empty) begin
                        r_state <= SS_IDLE;
                    end
                end
                SS_FAULT: begin
                    if (clear_i) begin
                        r_state <= enable_i ? SS_RUN : SS_IDLE;
                        r_cause <= SS_ERR_NONE;
                    end
                end
                default: r_state <= SS_IDLE;
            endcase
        end
    end

    assign stall_o         = w_stall;
    assign ss_write_o      = w_write;
    assign ss_read_o       = w_read;
    assign ss_pointer_wr_o = w_write ? w_head.value : 32'h0;
    assign ss_pointer_rd_o = w_read  ? w_head.value : 32'h0;
    assign fault_o         = r_fault;
    assign err_cause_o     = r_cause;
    assign ss_depth_o      = r_depth;

endmodule

// File: tb/tb_ibex_shadow_stack_ctrl.sv
// Randomised bench for ibex_shadow_stack_ctrl: a behavioural stack answers the strobes and a
// transaction-level model (op queue + list of return addresses) predicts every output per cycle.
module tb_ibex_shadow_stack_ctrl;

    localparam int AW   = 2;
    localparam int FD   = 4;
    localparam int MAXD = (1 << AW) - 1;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          instr_valid_i = 1'b0;
    logic [31:0]   instr_i = 32'h0;
    logic          instr_compressed_i = 1'b0;
    logic [31:0]   pc_i = 32'h0;
    logic [31:0]   jump_target_i = 32'h0;
    logic          stall_o;
    logic [31:0]   ss_pointer_wr_o;
    logic [31:0]   ss_pointer_rd_o;
    logic          ss_write_o;
    logic          ss_read_o;
    logic          ss_error_i;
    logic          fault_o;
    logic [1:0]    err_cause_o;
    logic [AW-1:0] ss_depth_o;

    always #5 clk = ~clk;

    ibex_shadow_stack_ctrl #(
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .enable_i           (enable_i),
        .clear_i            (clear_i),
        .instr_valid_i      (instr_valid_i),
        .instr_i            (instr_i),
        .instr_compressed_i (instr_compressed_i),
        .pc_i               (pc_i),
        .jump_target_i      (jump_target_i),
        .stall_o            (stall_o),
        .ss_pointer_wr_o    (ss_pointer_wr_o),
        .ss_pointer_rd_o    (ss_pointer_rd_o),
        .ss_write_o         (ss_write_o),
        .ss_read_o          (ss_read_o),
        .ss_error_i         (ss_error_i),
        .fault_o            (fault_o),
        .err_cause_o        (err_cause_o),
        .ss_depth_o         (ss_depth_o)
    );

    // Behavioural shadow stack reacting to the DUT's strobes (shares rst_n with the DUT).
    logic [31:0] env_mem [MAXD];
    int          env_sp;
    logic [31:0] env_top;

    always_comb begin
        env_top    = (env_sp > 0) ? env_mem[env_sp-1] : 32'h0;
        ss_error_i = 1'b0;
        if (ss_write_o && env_sp == MAXD) ss_error_i = 1'b1;
        if (ss_read_o && (env_sp == 0 || env_top != ss_pointer_rd_o)) ss_error_i = 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_sp <= 0;
        end else if (ss_write_o && env_sp < MAXD) begin
            env_mem[env_sp] <= ss_pointer_wr_o;
            env_sp <= env_sp + 1;
        end else if (ss_read_o && env_sp > 0) begin
            env_sp <= env_sp - 1;
        end
    end

    // Reference model
    typedef struct {
        bit          pop;
        logic [31:0] val;
    } op_t;

    op_t         m_q[$];
    logic [31:0] m_stack[$];
    int          m_state;
    bit          m_fault;
    int          m_cause;
    bit          m_last_stall;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_jal(input logic [4:0] rd);
        return {20'h00000, rd, 7'h6F};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [2:0] f3);
        return {12'h000, rs1, f3, rd, 7'h67};
    endfunction

    function automatic logic [4:0] pick_reg();
        int unsigned k = $urandom_range(0, 3);
        return (k == 0) ? 5'd0 : (k == 1) ? 5'd1 : (k == 2) ? 5'd5 : 5'd2;
    endfunction

    // RAS hint table: returns how many ops the instruction produces, in order a then b.
    function automatic int ref_decode(input logic [31:0] ins, input logic [31:0] pcv, input bit comp,
                                      input logic [31:0] tgt, output op_t a, output op_t b);
        logic [4:0] rd  = ins[11:7];
        logic [4:0] rs1 = ins[19:15];
        bit rdl = (rd == 5'd1) || (rd == 5'd5);
        bit rsl = (rs1 == 5'd1) || (rs1 == 5'd5);
        logic [31:0] ret = pcv + (comp ? 32'd2 : 32'd4);
        a.pop = 1'b0; a.val = ret;
        b.pop = 1'b0; b.val = ret;
        if (ins[6:0] == 7'h6F) return rdl ? 1 : 0;
        if (ins[6:0] != 7'h67 || ins[14:12] != 3'd0) return 0;
        if (rdl && rsl && rd != rs1) begin
            a.pop = 1'b1; a.val = tgt;
            return 2;
        end
        if (rdl) return 1;
        if (rsl) begin
            a.pop = 1'b1; a.val = tgt;
            return 1;
        end
        return 0;
    endfunction

    // Called right after a falling edge: drive, compare, advance the model, wait for next fall.
    task automatic step(input bit en, input bit clr, input bit vld, input logic [31:0] ins,
                        input bit comp, input logic [31:0] pcv, input logic [31:0] tgt);
        op_t h, a, b;
        bit has, exp_w, exp_r, exp_st, err, was_empty;
        int n, cause;
        enable_i = en; clear_i = clr; instr_valid_i = vld; instr_i = ins;
        instr_compressed_i = comp; pc_i = pcv; jump_target_i = tgt;
        #2;
        h.pop = 1'b0; h.val = 32'h0;
        has = (m_state == M_RUN) && (m_q.size() > 0);
        if (has) h = m_q[0];
        exp_w  = has && !h.pop;
        exp_r  = has && h.pop;
        exp_st = (m_state == M_RUN) && en && vld && ((FD - m_q.size()) < 2);
        err = 1'b0; cause = 0;
        if (exp_w && m_stack.size() == MAXD) begin err = 1'b1; cause = 1; end
        if (exp_r && m_stack.size() == 0) begin err = 1'b1; cause = 2; end
        else if (exp_r && m_stack[m_stack.size()-1] != h.val) begin err = 1'b1; cause = 3; end

        check("stall", 32'(stall_o), 32'(exp_st));
        check("write", 32'(ss_write_o), 32'(exp_w));
        check("read", 32'(ss_read_o), 32'(exp_r));
        check("ptr_wr", ss_pointer_wr_o, exp_w ? h.val : 32'h0);
        check("ptr_rd", ss_pointer_rd_o, exp_r ? h.val : 32'h0);
        check("fault", 32'(fault_o), 32'(m_fault));
        check("cause", 32'(err_cause_o), 32'(m_cause));
        check("depth", 32'(ss_depth_o), 32'(m_stack.size()));
        if (has)
            $display("t=%0t %s 0x%08h depth=%0d err=%0d", $time, h.pop ? "POP " : "PUSH",
                     h.val, m_stack.size(), cause);

        m_last_stall = exp_st;
        was_empty = (m_q.size() == 0);
        n = 0;
        if (m_state == M_RUN && en && vld && !exp_st) n = ref_decode(ins, pcv, comp, tgt, a, b);
        if (has) begin
            void'(m_q.pop_front());
            if (!h.pop && m_stack.size() < MAXD) m_stack.push_back(h.val);
            if (h.pop && m_stack.size() > 0) void'(m_stack.pop_back());
        end
        if (n >= 1) m_q.push_back(a);
        if (n == 2) m_q.push_back(b);
        m_fault = 1'b0;
        case (m_state)
            M_IDLE: if (en) m_state = M_RUN;
            M_RUN: begin
                if (err) begin
                    m_q.delete();
                    m_state = M_FAULT;
                    m_fault = 1'b1;
                    m_cause = cause;
                end else if (!en && was_empty) begin
                    m_state = M_IDLE;
                end
            end
            default: if (clr) begin
                m_state = en ? M_RUN : M_IDLE;
                m_cause = 0;
            end
        endcase
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) step(en, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        enable_i = 1'b1; clear_i = 1'b0; instr_valid_i = 1'b1;
        #2;
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_write", 32'(ss_write_o), 32'h0);
        check("rst_read", 32'(ss_read_o), 32'h0);
        check("rst_ptr_wr", ss_pointer_wr_o, 32'h0);
        check("rst_ptr_rd", ss_pointer_rd_o, 32'h0);
        check("rst_fault", 32'(fault_o), 32'h0);
        check("rst_cause", 32'(err_cause_o), 32'h0);
        check("rst_depth", 32'(ss_depth_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        m_q.delete();
        m_stack.delete();
        m_state = M_IDLE;
        m_fault = 1'b0;
        m_cause = 0;
        m_last_stall = 1'b0;
    endtask

    initial begin
        logic [31:0] prev, ins_r, pc_r, tgt_r;
        bit en_r, vld_r, comp_r, clr_r;
        int guard, k;

        @(negedge clk);
        do_reset();

        // Call then return
        idle(1, 1'b1);
        step(1, 0, 1, enc_jal(5'd1), 0, 32'h100, 32'h0);
        idle(1, 1'b1);
        step(1, 0, 1, enc_jalr(5'd0, 5'd1, 3'd0), 0, 32'h200, 32'h104);
        idle(2, 1'b1);

        // Return on an empty stack, then clear
        step(1, 0, 1, enc_jalr(5'd0, 5'd1, 3'd0), 0, 32'h200, 32'h50);
        idle(3, 1'b1);
        step(1, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        idle(1, 1'b1);

        // Return to the wrong address
        step(1, 0, 1, enc_jal(5'd1), 0, 32'h1FC, 32'h0);
        step(1, 0, 1, enc_jalr(5'd0, 5'd1, 3'd0), 0, 32'h204, 32'h300);
        idle(3, 1'b1);
        step(1, 1, 0, 32'h0, 0, 32'h0, 32'h0);

        // Compressed calls until the 3-deep stack overflows
        for (int i = 0; i < 4; i++) step(1, 0, 1, enc_jal(5'd1), 1, 32'h10, 32'h0);
        idle(3, 1'b1);
        step(0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        idle(2, 1'b0);

        // Back-to-back coroutine swaps fill the queue and exercise stall
        do_reset();
        idle(1, 1'b1);
        step(1, 0, 1, enc_jal(5'd1), 0, 32'h3FC, 32'h0);
        prev = 32'h400;
        for (int i = 0; i < 6; i++) begin
            guard = 0;
            do begin
                step(1, 0, 1, enc_jalr(5'd1, 5'd5, 3'd0), 0, 32'h80 + 32'(16 * i), prev);
                guard++;
            end while (m_last_stall && guard < 20);
            check("stall_bound", 32'(guard < 20), 32'h1);
            prev = 32'h84 + 32'(16 * i);
        end
        do_reset();

        // Random traffic with one reset in the middle
        en_r = 1'b1; vld_r = 1'b0; comp_r = 1'b0;
        ins_r = 32'h0; pc_r = 32'h100; tgt_r = 32'h104;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            if (!m_last_stall) begin
                en_r  = ($urandom_range(0, 19) != 0);
                vld_r = ($urandom_range(0, 9) < 7);
                k = $urandom_range(0, 9);
                if (k < 3)       ins_r = enc_jal(pick_reg());
                else if (k < 8)  ins_r = enc_jalr(pick_reg(), pick_reg(), 3'd0);
                else if (k == 8) ins_r = enc_jalr(pick_reg(), pick_reg(), 3'($urandom_range(1, 7)));
                else             ins_r = {17'h0, 3'd0, pick_reg(), 7'h13};
                comp_r = ($urandom_range(0, 3) == 0);
                pc_r = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFE
                                                    : 32'h100 + 32'(4 * $urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0:       tgt_r = (m_stack.size() > 0) ? m_stack[m_stack.size()-1] : 32'h104;
                    1:       tgt_r = 32'h100 + 32'(4 * $urandom_range(1, 4));
                    2:       tgt_r = 32'h102 + 32'(4 * $urandom_range(0, 3));
                    default: tgt_r = $urandom & 32'hFFFF_FFFE;
                endcase
            end
            clr_r = ($urandom_range(0, 9) < ((m_state == M_FAULT) ? 3 : 1));
            step(en_r, clr_r, vld_r, ins_r, comp_r, pc_r, tgt_r);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
